// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - classifies a debounced button level into press/release/click/long/repeat pulses
// Optional auto-repeat during long hold is enabled by defining BTN_AUTO_REPEAT_EN.
module button_press_classifier #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       press,
  output logic       release_pulse,
  output logic       short_click,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] event_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Elaboration-time range checks on the timing parameters.
  generate
    if (LONG_CYCLES < 2 || LONG_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_long
      $error("LONG_CYCLES out of range");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_repeat
      $error("REPEAT_CYCLES out of range");
    end
  endgenerate

  state_t           state, state_n;
  logic             in_q;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n, release_n, short_n, long_n, ev_inc;

  // Input stage: the FSM only ever looks at the registered copy of the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  // State, hold counter, event counter and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      event_cnt     <= 8'd0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      press         <= press_n;
      release_pulse <= release_n;
      short_click   <= short_n;
      long_press    <= long_n;
      if (ev_inc) begin
        event_cnt <= event_cnt + 8'd1;
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic repeat_n;

  // Registered auto-repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= repeat_n;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  // Next-state and next-pulse decode; release wins over long_press on the same edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    ev_inc    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    repeat_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_q) begin
          state_n = PRESSED;
          press_n = 1'b1;
          cnt_n   = '0;
        end
      end
      PRESSED: begin
        if (!in_q) begin
          state_n   = IDLE;
          release_n = 1'b1;
          short_n   = 1'b1;
          ev_inc    = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = LONG;
          long_n  = 1'b1;
          ev_inc  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      LONG: begin
        if (!in_q) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (cnt == REPEAT_LAST) begin
            repeat_n = 1'b1;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign held = (state != IDLE);

endmodule
